// File: rtl/seq_step_ctrl.sv
// Command-driven sequencer for the 4-bit ripple sequence counter.
// Issues step/reset pulses, tracks the expected value, and checks ctr_q after each pulse.
module seq_step_ctrl #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2,
  parameter int MAX_TO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [3:0]       ctr_q,
  output logic             ctr_step,
  output logic             ctr_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] steps_done,
  output logic [3:0]       exp_q
);

  localparam logic [1:0] OP_RUN    = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_RUN_TO = 2'b10;
  localparam int         WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {IDLE, RSTC, PULSE, WAIT, CHECK, DONE} state_t;

  state_t           state;
  logic [1:0]       op_lat;
  logic [CNT_W-1:0] arg_lat;
  logic [WW-1:0]    wait_cnt;

  logic [3:0]       nxt;
  logic             nxt_legal;
  logic [CNT_W-1:0] steps_inc;

  // Successor of the expected value; {legal, value}.
  function automatic logic [4:0] next_val(input logic [3:0] v);
    case (v)
      4'd0:    next_val = {1'b1, 4'd2};
      4'd2:    next_val = {1'b1, 4'd5};
      4'd5:    next_val = {1'b1, 4'd7};
      4'd7:    next_val = {1'b1, 4'd8};
      4'd8:    next_val = {1'b1, 4'd10};
      4'd10:   next_val = {1'b1, 4'd9};
      4'd9:    next_val = {1'b1, 4'd11};
      4'd11:   next_val = {1'b1, 4'd8};
      default: next_val = {1'b0, v};
    endcase
  endfunction

  always_comb begin
    {nxt_legal, nxt} = next_val(exp_q);
    steps_inc = (steps_done == {CNT_W{1'b1}}) ? steps_done : steps_done + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_lat     <= OP_RUN;
      arg_lat    <= '0;
      wait_cnt   <= '0;
      cmd_ready  <= 1'b1;
      ctr_step   <= 1'b0;
      ctr_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      steps_done <= '0;
      exp_q      <= 4'd0;
    end else begin
      ctr_step <= 1'b0;
      ctr_rst  <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            steps_done <= '0;
            op_lat     <= cmd_op;
            arg_lat    <= cmd_arg;
            case (cmd_op)
              OP_RESET: begin
                state   <= RSTC;
                ctr_rst <= 1'b1;
              end
              OP_RUN: begin
                if (cmd_arg == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state    <= PULSE;
                  ctr_step <= 1'b1;
                end
              end
              OP_RUN_TO: begin
                if (cmd_arg[3:0] == exp_q) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state    <= PULSE;
                  ctr_step <= 1'b1;
                end
              end
              default: begin
                err   <= 1'b1;
                state <= DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        RSTC, PULSE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_cnt == WW'(SETTLE - 1)) state <= CHECK;
          else                             wait_cnt <= wait_cnt + WW'(1);
        end
        CHECK: begin
          if (op_lat == OP_RESET) begin
            exp_q <= 4'd0;
            if (ctr_q != 4'd0) err <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
          end else if (!nxt_legal) begin
            err   <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            exp_q      <= nxt;
            steps_done <= steps_inc;
            if (ctr_q != nxt) begin
              err   <= 1'b1;
              state <= DONE;
              done  <= 1'b1;
            end else if (op_lat == OP_RUN) begin
              if (steps_inc >= arg_lat) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= PULSE;
                ctr_step <= 1'b1;
              end
            end else if (nxt == arg_lat[3:0]) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (steps_inc >= CNT_W'(MAX_TO)) begin
              // Target not reached within the step limit.
              err   <= 1'b1;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= PULSE;
              ctr_step <= 1'b1;
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed bench for seq_step_ctrl with a behavioural model of the sequence counter.
module tb_seq_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'd0;
  logic [3:0] ctr_q;
  logic       ctr_step, ctr_rst, busy, done, err;
  logic [7:0] steps_done;
  logic [3:0] exp_q;

  seq_step_ctrl #(.CNT_W(8), .SETTLE(2), .MAX_TO(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ctr_q(ctr_q), .ctr_step(ctr_step),
    .ctr_rst(ctr_rst), .busy(busy), .done(done), .err(err),
    .steps_done(steps_done), .exp_q(exp_q)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // External counter: advances on ctr_step rising edge, cleared by ctr_rst.
  function automatic logic [3:0] seq_next(input logic [3:0] v);
    case (v)
      4'd0: return 4'd2;   4'd2: return 4'd5;   4'd5: return 4'd7;  4'd7: return 4'd8;
      4'd8: return 4'd10;  4'd10: return 4'd9;  4'd9: return 4'd11; 4'd11: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  logic [3:0] cnt = 4'd0;
  logic       stuck = 1'b0;
  always @(posedge ctr_step or posedge ctr_rst) begin
    if (ctr_rst) cnt <= 4'd0;
    else         cnt <= seq_next(cnt);
  end
  assign ctr_q = stuck ? 4'd0 : cnt;

  int         cyc = 0;
  int         step_cnt = 0, done_cnt = 0, rstp_cnt = 0, viol = 0, exp_n = 0;
  int         step_cyc [256];
  logic [3:0] exp_hist [256];
  logic       prev_step = 1'b0;
  logic [3:0] prev_exp = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ctr_step) begin
      step_cyc[step_cnt % 256] <= cyc;
      step_cnt <= step_cnt + 1;
    end
    if ((ctr_step && prev_step) || (ctr_step && ctr_rst)) viol <= viol + 1;
    if (ctr_rst && rst) rstp_cnt <= rstp_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (exp_q != prev_exp) begin
      exp_hist[exp_n % 256] <= exp_q;
      exp_n <= exp_n + 1;
    end
    prev_step <= ctr_step;
    prev_exp  <= exp_q;
  end

  int acc_cyc;

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
    int t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    n_chk++;
    if (!cmd_ready) begin n_fail++; $display("FAIL cmd_ready_wait: cmd_ready=%0b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_arg = 8'hA5;
    $display("cmd op=%0d arg=%0d accepted at cycle %0d", op, arg, acc_cyc);
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < max);
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n); end
    @(negedge clk); #1;
    $display("done after %0d cycles: exp_q=%0d steps_done=%0d err=%0b", n, exp_q, steps_done, err);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({ctr_rst, ctr_step, busy, done, err, cmd_ready} !== 6'b100001) begin
      n_fail++; $display("FAIL reset_ctl: {rst,step,busy,done,err,ready}=%b required 100001", {ctr_rst, ctr_step, busy, done, err, cmd_ready}); end
    n_chk++; if (steps_done !== 8'd0 || exp_q !== 4'd0) begin
      n_fail++; $display("FAIL reset_vals: steps_done=%0d exp_q=%0d required 0 0", steps_done, exp_q); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (ctr_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release: ctr_rst=%0b required 0", ctr_rst); end
    $display("reset released");
  endtask

  task automatic test_run8;
    logic [3:0] e [8] = '{4'd2, 4'd5, 4'd7, 4'd8, 4'd10, 4'd9, 4'd11, 4'd8};
    int sb = step_cnt, eb = exp_n, db = done_cnt, n;
    send_cmd(2'b00, 8'd8);
    wait_done(100, n);
    n_chk++; if (step_cnt - sb != 8) begin n_fail++; $display("FAIL run8_steps: pulses=%0d required 8", step_cnt - sb); end
    n_chk++; if (exp_n - eb != 8) begin n_fail++; $display("FAIL run8_hist_len: changes=%0d required 8", exp_n - eb); end
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (exp_hist[(eb + k) % 256] !== e[k]) begin
        n_fail++; $display("FAIL run8_exp[%0d]: exp_q=%0d required %0d", k, exp_hist[(eb + k) % 256], e[k]); end
    end
    for (int k = 1; k < 8; k++) begin
      n_chk++; if (step_cyc[(sb + k) % 256] - step_cyc[(sb + k - 1) % 256] != 4) begin
        n_fail++; $display("FAIL run8_period[%0d]: gap=%0d required 4", k, step_cyc[(sb + k) % 256] - step_cyc[(sb + k - 1) % 256]); end
    end
    n_chk++; if (steps_done !== 8'd8 || err !== 1'b0 || done_cnt - db != 1) begin
      n_fail++; $display("FAIL run8_end: steps_done=%0d err=%0b dones=%0d required 8 0 1", steps_done, err, done_cnt - db); end
  endtask

  task automatic test_run0;
    int sb = step_cnt, n;
    send_cmd(2'b00, 8'd0);
    wait_done(10, n);
    n_chk++; if (n > 2) begin n_fail++; $display("FAIL run0_latency: cycles=%0d required <=2", n); end
    n_chk++; if (step_cnt != sb || steps_done !== 8'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL run0_end: pulses=%0d steps_done=%0d err=%0b required 0 0 0", step_cnt - sb, steps_done, err); end
    n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL run0_ready: cmd_ready=%0b busy=%0b required 1 0", cmd_ready, busy); end
  endtask

  task automatic test_run_to;
    int sb = step_cnt, eb = exp_n, n;
    send_cmd(2'b10, 8'd11);
    wait_done(100, n);
    n_chk++; if (step_cnt - sb != 3 || exp_q !== 4'd11 || err !== 1'b0 || steps_done !== 8'd3) begin
      n_fail++; $display("FAIL runto11: pulses=%0d exp_q=%0d err=%0b steps_done=%0d required 3 11 0 3", step_cnt - sb, exp_q, err, steps_done); end
    n_chk++; if (exp_hist[eb % 256] !== 4'd10 || exp_hist[(eb + 1) % 256] !== 4'd9) begin
      n_fail++; $display("FAIL runto11_seq: %0d,%0d required 10,9", exp_hist[eb % 256], exp_hist[(eb + 1) % 256]); end
    sb = step_cnt;
    send_cmd(2'b10, 8'd5);
    wait_done(100, n);
    n_chk++; if (step_cnt - sb != 8 || err !== 1'b1 || steps_done !== 8'd8 || exp_q !== 4'd11) begin
      n_fail++; $display("FAIL runto5: pulses=%0d err=%0b steps_done=%0d exp_q=%0d required 8 1 8 11", step_cnt - sb, err, steps_done, exp_q); end
  endtask

  task automatic test_reserved;
    int sb = step_cnt, rb = rstp_cnt, n;
    send_cmd(2'b11, 8'd3);
    wait_done(10, n);
    n_chk++; if (err !== 1'b1 || step_cnt != sb || rstp_cnt != rb || steps_done !== 8'd0 || exp_q !== 4'd11) begin
      n_fail++; $display("FAIL reserved: err=%0b pulses=%0d rst=%0d steps_done=%0d exp_q=%0d required 1 0 0 0 11", err, step_cnt - sb, rstp_cnt - rb, steps_done, exp_q); end
  endtask

  task automatic test_stuck;
    int sb, db, n;
    stuck = 1'b1;
    sb = step_cnt; db = done_cnt;
    send_cmd(2'b00, 8'd4);
    wait_done(100, n);
    repeat (10) @(negedge clk);
    #1;
    n_chk++; if (err !== 1'b1 || steps_done !== 8'd1 || step_cnt - sb != 1 || done_cnt - db != 1) begin
      n_fail++; $display("FAIL stuck: err=%0b steps_done=%0d pulses=%0d dones=%0d required 1 1 1 1", err, steps_done, step_cnt - sb, done_cnt - db); end
    n_chk++; if (exp_q !== 4'd8) begin n_fail++; $display("FAIL stuck_exp: exp_q=%0d required 8", exp_q); end
    stuck = 1'b0;
  endtask

  task automatic test_busy_ignore;
    int rb = rstp_cnt, sb = step_cnt, n;
    send_cmd(2'b00, 8'd2);
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(100, n);
    n_chk++; if (rstp_cnt != rb || step_cnt - sb != 2 || exp_q !== 4'd9 || err !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore: rst=%0d pulses=%0d exp_q=%0d err=%0b required 0 2 9 0", rstp_cnt - rb, step_cnt - sb, exp_q, err); end
  endtask

  task automatic test_reset_cmd;
    int rb = rstp_cnt, sb = step_cnt, db = done_cnt, n;
    send_cmd(2'b01, 8'd0);
    wait_done(20, n);
    n_chk++; if (rstp_cnt - rb != 1 || step_cnt != sb || exp_q !== 4'd0 || err !== 1'b0 || done_cnt - db != 1) begin
      n_fail++; $display("FAIL reset_cmd: rst=%0d pulses=%0d exp_q=%0d err=%0b dones=%0d required 1 0 0 0 1", rstp_cnt - rb, step_cnt - sb, exp_q, err, done_cnt - db); end
    send_cmd(2'b00, 8'd1);
    wait_done(20, n);
    n_chk++; if (exp_q !== 4'd2 || steps_done !== 8'd1 || err !== 1'b0) begin
      n_fail++; $display("FAIL run1_after_reset: exp_q=%0d steps_done=%0d err=%0b required 2 1 0", exp_q, steps_done, err); end
  endtask

  task automatic test_abort;
    int sb, db, t;
    send_cmd(2'b00, 8'd0);
    @(negedge clk); @(negedge clk);
    sb = step_cnt; db = done_cnt;
    send_cmd(2'b00, 8'd6);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (step_cnt - sb < 3 && t < 100);
    n_chk++; if (step_cnt - sb != 3) begin n_fail++; $display("FAIL abort_reach: pulses=%0d required 3", step_cnt - sb); end
    rst = 1'b0;
    #1;
    n_chk++; if (ctr_rst !== 1'b1 || busy !== 1'b0 || ctr_step !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: ctr_rst=%0b busy=%0b ctr_step=%0b required 1 0 0", ctr_rst, busy, ctr_step); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (cmd_ready !== 1'b1 || exp_q !== 4'd0 || ctr_rst !== 1'b0 || done_cnt != db) begin
      n_fail++; $display("FAIL abort_after: cmd_ready=%0b exp_q=%0d ctr_rst=%0b dones=%0d required 1 0 0 0", cmd_ready, exp_q, ctr_rst, done_cnt - db); end
    n_chk++; if (viol != 0) begin n_fail++; $display("FAIL pulse_rules: violations=%0d required 0", viol); end
  endtask

  initial begin
    test_reset;
    test_run8;
    test_run0;
    test_run_to;
    test_reserved;
    test_stuck;
    test_busy_ignore;
    test_reset_cmd;
    test_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
